// File: rtl/mem_stage.sv
// Memory stage: one data-memory op per cycle (load/store/push/pop), owns data RAM and SP.
// Latency: 1 cycle into the MEM/WB boundary registers.
// Backpressure: stall holds all state and outputs; flush inserts a bubble and blocks side effects.
module mem_stage #(
    parameter int ADDR_W = 11,
    // ISA word size; the datapath assumes 16 bits, do not override.
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              push,
    input  logic              pop,
    input  logic              reg_write_in,
    input  logic              mem_to_reg_in,
    input  logic [2:0]        rd_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    output logic [DATA_W-1:0] mem_data_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [2:0]        rd_out,
    output logic              reg_write_out,
    output logic              mem_to_reg_out,
    output logic [ADDR_W-1:0] sp_out,
    output logic              fault
);

    localparam int DEPTH = 1 << ADDR_W;

    // SP points at the next free slot; the stack grows downward from the top word.
    localparam logic [ADDR_W-1:0] SP_EMPTY = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] SP_FULL  = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] SP_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_sp;
    logic              r_fault;
    logic [DATA_W-1:0] r_mem_data;
    logic [DATA_W-1:0] r_alu_result;
    logic [2:0]        r_rd;
    logic              r_reg_write;
    logic              r_mem_to_reg;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [2:0]        w_op_cnt;
    logic              w_multi;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_sp_inc;
    logic [ADDR_W-1:0] w_sp_dec;
    logic              w_sp_empty;
    logic              w_sp_full;
    logic              w_load_ok;
    logic              w_store_ok;
    logic              w_push_ok;
    logic              w_pop_ok;
    logic              w_err;
    logic              w_advance;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0] w_rd_data;
    logic [ADDR_W-1:0] w_sp_next;

    // Classify the requested operation and decide whether it is legal this cycle.
    always_comb begin
        w_op_cnt   = {2'b00, mem_read} + {2'b00, mem_write} + {2'b00, push} + {2'b00, pop};
        w_multi    = (w_op_cnt > 3'd1);
        // Upper address bits are dropped so addresses alias modulo DEPTH.
        w_addr     = alu_result[ADDR_W-1:0];
        w_sp_inc   = r_sp + SP_ONE;
        w_sp_dec   = r_sp - SP_ONE;
        w_sp_empty = (r_sp == SP_EMPTY);
        w_sp_full  = (r_sp == SP_FULL);

        w_load_ok  = mem_read  & ~w_multi;
        w_store_ok = mem_write & ~w_multi;
        w_push_ok  = push & ~w_multi & ~w_sp_full;
        w_pop_ok   = pop  & ~w_multi & ~w_sp_empty;

        // Conflicting ops, push onto a full stack, or pop from an empty one.
        w_err      = w_multi
                   | (push & ~w_multi & w_sp_full)
                   | (pop  & ~w_multi & w_sp_empty);

        // Only a normal (non-flushed, non-stalled) cycle may have side effects.
        w_advance  = ~stall & ~flush;
    end

    // Select memory write port and SP update for the accepted operation.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = w_addr;
        w_sp_next   = r_sp;
        if (w_push_ok) begin
            w_mem_waddr = r_sp;
            w_sp_next   = w_sp_dec;
        end else if (w_pop_ok) begin
            w_sp_next   = w_sp_inc;
        end
        w_mem_we = w_advance & (w_store_ok | w_push_ok);
    end

    // Read data for loads and pops; zero for every other case including errors.
    always_comb begin
        w_rd_data = '0;
        if (w_load_ok) begin
            w_rd_data = r_mem[w_addr];
        end else if (w_pop_ok) begin
            w_rd_data = r_mem[w_sp_inc];
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Data memory: no reset on contents; a write is dropped on any edge where rst is high.
    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            r_mem[w_mem_waddr] <= store_data;
        end
    end

    // Stack pointer: moves only on an accepted push/pop in a normal cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp <= SP_EMPTY;
        end else if (w_advance) begin
            r_sp <= w_sp_next;
        end
    end

    // Sticky fault: set on any rejected op in a normal cycle, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (w_advance && w_err) begin
            r_fault <= 1'b1;
        end
    end

    // MEM/WB boundary registers: flush bubbles, stall holds, otherwise capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_data   <= '0;
            r_alu_result <= '0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (flush) begin
            r_mem_data   <= '0;
            r_alu_result <= '0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (!stall) begin
            r_mem_data   <= w_rd_data;
            r_alu_result <= alu_result;
            r_rd         <= rd_in;
            // A rejected op must never reach the register file.
            r_reg_write  <= reg_write_in & ~w_err;
            r_mem_to_reg <= mem_to_reg_in;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_data_out   = r_mem_data;
    assign alu_result_out = r_alu_result;
    assign rd_out         = r_rd;
    assign reg_write_out  = r_reg_write;
    assign mem_to_reg_out = r_mem_to_reg;
    assign sp_out         = r_sp;
    assign fault          = r_fault;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table through a scoreboard queue, plus reset/underflow/overflow sequences.
// A second instance with ADDR_W = 2 exercises the full-stack path.
// Outputs are sampled 1 time unit after each rising edge.
module tb_mem_stage;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LD  = 4'b1000;
    localparam logic [3:0] OP_ST  = 4'b0100;
    localparam logic [3:0] OP_PU  = 4'b0010;
    localparam logic [3:0] OP_PO  = 4'b0001;

    typedef struct {
        logic        sel;     // 0: default instance, 1: ADDR_W=2 instance
        logic [3:0]  op;      // {mem_read, mem_write, push, pop}
        logic [1:0]  fs;      // {flush, stall}
        logic        rw;
        logic        m2r;
        logic [2:0]  rdi;
        logic [15:0] alu;
        logic [15:0] sd;
        logic [15:0] e_mdo;
        logic [15:0] e_alu;
        logic [2:0]  e_rd;
        logic        e_rw;
        logic        e_m2r;
        logic [10:0] e_sp;
        logic        e_fault;
    } vec_t;

    logic        clk = 1'b0;
    logic        clk_en = 1'b1;
    logic        rst = 1'b1;
    logic        stall = 1'b0, flush = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0, push = 1'b0, pop = 1'b0;
    logic        reg_write_in = 1'b0, mem_to_reg_in = 1'b0;
    logic [2:0]  rd_in = '0;
    logic [15:0] alu_result = '0, store_data = '0;

    logic [15:0] m_mdo, m_alu, s_mdo, s_alu;
    logic [2:0]  m_rd, s_rd;
    logic        m_rw, m_m2r, m_fault, s_rw, s_m2r, s_fault;
    logic [10:0] m_sp;
    logic [1:0]  s_sp;

    int total = 0;
    int bad = 0;
    vec_t exp_q[$];
    vec_t tbl[$];

    mem_stage u_dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_read(mem_read), .mem_write(mem_write), .push(push), .pop(pop),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in), .rd_in(rd_in),
        .alu_result(alu_result), .store_data(store_data),
        .mem_data_out(m_mdo), .alu_result_out(m_alu), .rd_out(m_rd),
        .reg_write_out(m_rw), .mem_to_reg_out(m_m2r), .sp_out(m_sp), .fault(m_fault)
    );

    mem_stage #(.ADDR_W(2)) u_small (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_read(mem_read), .mem_write(mem_write), .push(push), .pop(pop),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in), .rd_in(rd_in),
        .alu_result(alu_result), .store_data(store_data),
        .mem_data_out(s_mdo), .alu_result_out(s_alu), .rd_out(s_rd),
        .reg_write_out(s_rw), .mem_to_reg_out(s_m2r), .sp_out(s_sp), .fault(s_fault)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    function automatic vec_t mk(input logic sel, input logic [3:0] op, input logic [1:0] fs,
                                input logic rw, input logic m2r, input logic [2:0] rdi,
                                input logic [15:0] alu, input logic [15:0] sd,
                                input logic [15:0] e_mdo, input logic [15:0] e_alu,
                                input logic [2:0] e_rd, input logic e_rw, input logic e_m2r,
                                input logic [10:0] e_sp, input logic e_fault);
        vec_t v;
        v.sel = sel; v.op = op; v.fs = fs; v.rw = rw; v.m2r = m2r; v.rdi = rdi;
        v.alu = alu; v.sd = sd; v.e_mdo = e_mdo; v.e_alu = e_alu; v.e_rd = e_rd;
        v.e_rw = e_rw; v.e_m2r = e_m2r; v.e_sp = e_sp; v.e_fault = e_fault;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input vec_t e);
        if (!e.sel) begin
            chk({tag, " mem_data_out"},   {16'h0, m_mdo},  {16'h0, e.e_mdo});
            chk({tag, " alu_result_out"}, {16'h0, m_alu},  {16'h0, e.e_alu});
            chk({tag, " rd_out"},         {29'h0, m_rd},   {29'h0, e.e_rd});
            chk({tag, " reg_write_out"},  {31'h0, m_rw},   {31'h0, e.e_rw});
            chk({tag, " mem_to_reg_out"}, {31'h0, m_m2r},  {31'h0, e.e_m2r});
            chk({tag, " sp_out"},         {21'h0, m_sp},   {21'h0, e.e_sp});
            chk({tag, " fault"},          {31'h0, m_fault}, {31'h0, e.e_fault});
        end else begin
            chk({tag, " s.mem_data_out"},   {16'h0, s_mdo},  {16'h0, e.e_mdo});
            chk({tag, " s.alu_result_out"}, {16'h0, s_alu},  {16'h0, e.e_alu});
            chk({tag, " s.rd_out"},         {29'h0, s_rd},   {29'h0, e.e_rd});
            chk({tag, " s.reg_write_out"},  {31'h0, s_rw},   {31'h0, e.e_rw});
            chk({tag, " s.mem_to_reg_out"}, {31'h0, s_m2r},  {31'h0, e.e_m2r});
            chk({tag, " s.sp_out"},         {30'h0, s_sp},   {21'h0, e.e_sp});
            chk({tag, " s.fault"},          {31'h0, s_fault}, {31'h0, e.e_fault});
        end
    endtask

    // Drive one vector, queue its expectation, then compare after the next rising edge.
    task automatic run_vec(input string tag, input vec_t v);
        vec_t e;
        {mem_read, mem_write, push, pop} = v.op;
        {flush, stall} = v.fs;
        reg_write_in  = v.rw;
        mem_to_reg_in = v.m2r;
        rd_in         = v.rdi;
        alu_result    = v.alu;
        store_data    = v.sd;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s scoreboard: got empty queue expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk_outs(tag, e);
        end
    endtask

    // Asynchronous reset with the clock parked low; outputs must clear without an edge.
    task automatic reset_stopped(input string tag);
        @(negedge clk);
        clk_en = 1'b0;
        {mem_read, mem_write, push, pop} = OP_NOP;
        {flush, stall} = 2'b00;
        #2 rst = 1'b1;
        #1;
        chk_outs({tag, " main"}, mk(0, OP_NOP, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 11'd2047, 0));
        chk_outs({tag, " small"}, mk(1, OP_NOP, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 11'd3, 0));
        rst = 1'b0;
        #1 clk_en = 1'b1;
    endtask

    initial begin
        // Default instance: store/load, aliasing, stack, stall, flush, conflicting ops.
        //            sel op     fs     rw m2r rd alu       sd        mdo       alu_o     rd rw m2r sp   f
        tbl.push_back(mk(0, OP_ST, 2'b00, 0, 0, 0, 16'h0005, 16'hBEEF, 16'h0000, 16'h0005, 0, 0, 0, 2047, 0));
        tbl.push_back(mk(0, OP_LD, 2'b00, 1, 1, 3, 16'h0005, 16'h0000, 16'hBEEF, 16'h0005, 3, 1, 1, 2047, 0));
        tbl.push_back(mk(0, OP_LD, 2'b00, 1, 1, 4, 16'hF805, 16'h0000, 16'hBEEF, 16'hF805, 4, 1, 1, 2047, 0));
        tbl.push_back(mk(0, OP_NOP, 2'b00, 1, 0, 2, 16'h1234, 16'h9999, 16'h0000, 16'h1234, 2, 1, 0, 2047, 0));
        tbl.push_back(mk(0, OP_PU, 2'b00, 0, 0, 0, 16'h0000, 16'h1111, 16'h0000, 16'h0000, 0, 0, 0, 2046, 0));
        tbl.push_back(mk(0, OP_PU, 2'b00, 0, 0, 0, 16'h0000, 16'h2222, 16'h0000, 16'h0000, 0, 0, 0, 2045, 0));
        tbl.push_back(mk(0, OP_PO, 2'b00, 1, 1, 5, 16'h0000, 16'h0000, 16'h2222, 16'h0000, 5, 1, 1, 2046, 0));
        tbl.push_back(mk(0, OP_PO, 2'b00, 1, 1, 6, 16'h0000, 16'h0000, 16'h1111, 16'h0000, 6, 1, 1, 2047, 0));
        tbl.push_back(mk(0, OP_PU, 2'b00, 1, 0, 2, 16'h0010, 16'h3333, 16'h0000, 16'h0010, 2, 1, 0, 2046, 0));
        tbl.push_back(mk(0, OP_PU, 2'b01, 0, 1, 5, 16'h0077, 16'h4444, 16'h0000, 16'h0010, 2, 1, 0, 2046, 0));
        tbl.push_back(mk(0, OP_ST, 2'b00, 0, 0, 0, 16'h0020, 16'hCAFE, 16'h0000, 16'h0020, 0, 0, 0, 2046, 0));
        tbl.push_back(mk(0, OP_ST, 2'b11, 1, 1, 5, 16'h0020, 16'hDEAD, 16'h0000, 16'h0000, 0, 0, 0, 2046, 0));
        tbl.push_back(mk(0, OP_LD, 2'b00, 1, 1, 1, 16'h0020, 16'h0000, 16'hCAFE, 16'h0020, 1, 1, 1, 2046, 0));
        tbl.push_back(mk(0, OP_PO, 2'b00, 1, 1, 3, 16'h0000, 16'h0000, 16'h3333, 16'h0000, 3, 1, 1, 2047, 0));
        tbl.push_back(mk(0, OP_LD, 2'b00, 0, 1, 0, 16'h07FE, 16'h0000, 16'h2222, 16'h07FE, 0, 0, 1, 2047, 0));
        tbl.push_back(mk(0, OP_LD | OP_PU, 2'b00, 1, 0, 4, 16'h0005, 16'h5555, 16'h0000, 16'h0005, 4, 0, 0, 2047, 1));
        tbl.push_back(mk(0, OP_LD, 2'b00, 1, 1, 2, 16'h07FF, 16'h0000, 16'h3333, 16'h07FF, 2, 1, 1, 2047, 1));

        // Reset asserted at time zero across the first edge.
        #12;
        chk_outs("por main", mk(0, OP_NOP, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 11'd2047, 0));
        chk_outs("por small", mk(1, OP_NOP, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 11'd3, 0));
        rst = 1'b0;

        foreach (tbl[i]) run_vec($sformatf("v%0d", i), tbl[i]);

        // Reset with clock stopped clears outputs and fault, keeps memory.
        reset_stopped("rst_stopped");

        // Underflow at reset SP, then fault stays set through a valid load of retained data.
        run_vec("underflow", mk(0, OP_PO, 2'b00, 1, 1, 7, 16'h00AA, 16'h0000, 16'h0000, 16'h00AA, 7, 0, 1, 2047, 1));
        run_vec("sticky",    mk(0, OP_LD, 2'b00, 1, 1, 1, 16'h0005, 16'h0000, 16'hBEEF, 16'h0005, 1, 1, 1, 2047, 1));

        // Overflow on the ADDR_W=2 instance: three pushes fill it, the fourth is rejected.
        reset_stopped("rst_small");
        run_vec("ov st0",  mk(1, OP_ST, 2'b00, 0, 0, 0, 16'h0000, 16'h0ABC, 16'h0000, 16'h0000, 0, 0, 0, 3, 0));
        run_vec("ov pu1",  mk(1, OP_PU, 2'b00, 0, 0, 0, 16'h0000, 16'h00A1, 16'h0000, 16'h0000, 0, 0, 0, 2, 0));
        run_vec("ov pu2",  mk(1, OP_PU, 2'b00, 0, 0, 0, 16'h0000, 16'h00A2, 16'h0000, 16'h0000, 0, 0, 0, 1, 0));
        run_vec("ov pu3",  mk(1, OP_PU, 2'b00, 0, 0, 0, 16'h0000, 16'h00A3, 16'h0000, 16'h0000, 0, 0, 0, 0, 0));
        run_vec("ov pu4",  mk(1, OP_PU, 2'b00, 1, 0, 1, 16'h0000, 16'h00A4, 16'h0000, 16'h0000, 1, 0, 0, 0, 1));
        run_vec("ov ld0",  mk(1, OP_LD, 2'b00, 1, 1, 2, 16'h0000, 16'h0000, 16'h0ABC, 16'h0000, 2, 1, 1, 0, 1));
        run_vec("ov po",   mk(1, OP_PO, 2'b00, 1, 1, 3, 16'h0000, 16'h0000, 16'h00A3, 16'h0000, 3, 1, 1, 1, 1));

        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard drain: got %0d entries expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
